// File: rtl/bpu_upd_arb.sv
// Branch-predictor update arbiter: round-robin ex/cm grant into a small FIFO drained onto the BTB write port.
// Optional BPU_UPD_COALESCE_EN merges a same-PC update into the youngest queued entry.
module bpu_upd_arb #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_vld,
  output logic                     ex_rdy,
  input  logic [PC_W-1:0]          ex_pc,
  input  logic [PC_W-1:0]          ex_target,
  input  logic [2:0]               ex_type,
  input  logic                     ex_taken,
  input  logic                     cm_vld,
  output logic                     cm_rdy,
  input  logic [PC_W-1:0]          cm_pc,
  input  logic [PC_W-1:0]          cm_target,
  input  logic [2:0]               cm_type,
  input  logic                     cm_taken,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     btb_wr_req,
  output logic [PC_W-1:0]          btb_wr_pc,
  output logic [PC_W-1:0]          btb_wr_predict_pc,
  output logic [2:0]               btb_wr_type,
  output logic                     btb_wr_taken,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  typedef enum logic {RR_EX = 1'b0, RR_CM = 1'b1} rr_e;

  logic [PC_W-1:0]  pc_mem_q  [DEPTH];
  logic [PC_W-1:0]  tgt_mem_q [DEPTH];
  logic [2:0]       type_mem_q[DEPTH];
  logic [DEPTH-1:0] taken_mem_q;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0] occ_q, occ_d;
  rr_e           rr_q, rr_d;

  logic            full, empty, rdy, deq;
  logic            ex_req, cm_req, grant_cm, grant_ex, grant, alloc;
  logic [AW-1:0]   widx;
  logic [PC_W-1:0] in_pc, in_tgt;
  logic [2:0]      in_type;
  logic            in_taken;

  // Grant selection and incoming payload mux
  always_comb begin
    full     = (occ_q == OW'(DEPTH));
    empty    = (occ_q == '0);
    rdy      = !full && !flush;
    deq      = !empty && !hold && !flush;
    ex_req   = ex_vld && rdy;
    cm_req   = cm_vld && rdy;
    grant_cm = cm_req && (!ex_req || (rr_q == RR_CM));
    grant_ex = ex_req && !grant_cm;
    grant    = grant_cm || grant_ex;
    in_pc    = grant_cm ? cm_pc     : ex_pc;
    in_tgt   = grant_cm ? cm_target : ex_target;
    in_type  = grant_cm ? cm_type   : ex_type;
    in_taken = grant_cm ? cm_taken  : ex_taken;
  end

`ifdef BPU_UPD_COALESCE_EN
  logic [AW-1:0] young_idx;
  logic          coal;

  // Youngest entry is mergeable only if it is not leaving the FIFO this cycle
  always_comb begin
    young_idx = wptr_q - AW'(1);
    coal      = grant && (in_pc == pc_mem_q[young_idx]) &&
                ((occ_q >= OW'(2)) || ((occ_q == OW'(1)) && !deq));
    alloc     = grant && !coal;
    widx      = coal ? young_idx : wptr_q;
  end
`else
  always_comb begin
    alloc = grant;
    widx  = wptr_q;
  end
`endif

  // Pointer, occupancy and round-robin next state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    rr_d   = rr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      if (alloc) wptr_d = wptr_q + AW'(1);
      if (deq)   rptr_d = rptr_q + AW'(1);
      occ_d = occ_q + OW'(alloc) - OW'(deq);
    end
    if (ex_req && cm_req) rr_d = grant_cm ? RR_EX : RR_CM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      rr_q   <= RR_CM;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      rr_q   <= rr_d;
    end
  end

  // Entry storage; contents are don't-care while not counted by occ
  always_ff @(posedge clk) begin
    if (grant) begin
      pc_mem_q[widx]    <= in_pc;
      tgt_mem_q[widx]   <= in_tgt;
      type_mem_q[widx]  <= in_type;
      taken_mem_q[widx] <= in_taken;
    end
  end

  assign ex_rdy            = rdy;
  assign cm_rdy            = rdy;
  assign btb_wr_req        = deq;
  assign btb_wr_pc         = empty ? '0 : pc_mem_q[rptr_q];
  assign btb_wr_predict_pc = empty ? '0 : tgt_mem_q[rptr_q];
  assign btb_wr_type       = empty ? '0 : type_mem_q[rptr_q];
  assign btb_wr_taken      = empty ? 1'b0 : taken_mem_q[rptr_q];
  assign occ               = occ_q;

endmodule

// File: tb/tb_bpu_upd_arb.sv
// Directed bench for bpu_upd_arb (DEPTH=4, PC_W=64); expectations follow BPU_UPD_COALESCE_EN.
module tb_bpu_upd_arb;

  logic        clk, rst;
  logic        ex_vld, ex_rdy, ex_taken;
  logic [63:0] ex_pc, ex_target;
  logic [2:0]  ex_type;
  logic        cm_vld, cm_rdy, cm_taken;
  logic [63:0] cm_pc, cm_target;
  logic [2:0]  cm_type;
  logic        hold, flush;
  logic        btb_wr_req, btb_wr_taken;
  logic [63:0] btb_wr_pc, btb_wr_predict_pc;
  logic [2:0]  btb_wr_type;
  logic [2:0]  occ;

  int n_chk = 0;
  int n_err = 0;

  bpu_upd_arb #(.DEPTH(4), .PC_W(64)) dut (
    .clk(clk), .rst(rst),
    .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_type(ex_type), .ex_taken(ex_taken),
    .cm_vld(cm_vld), .cm_rdy(cm_rdy), .cm_pc(cm_pc), .cm_target(cm_target),
    .cm_type(cm_type), .cm_taken(cm_taken),
    .hold(hold), .flush(flush),
    .btb_wr_req(btb_wr_req), .btb_wr_pc(btb_wr_pc),
    .btb_wr_predict_pc(btb_wr_predict_pc), .btb_wr_type(btb_wr_type),
    .btb_wr_taken(btb_wr_taken), .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    ex_vld = 1'b0; ex_pc = '0; ex_target = '0; ex_type = '0; ex_taken = 1'b0;
    cm_vld = 1'b0; cm_pc = '0; cm_target = '0; cm_type = '0; cm_taken = 1'b0;
    #12;
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_req", 64'(btb_wr_req), 64'd0);
    chk("rst_pc", btb_wr_pc, 64'd0);
    chk("rst_exrdy", 64'(ex_rdy), 64'd1);
    chk("rst_cmrdy", 64'(cm_rdy), 64'd1);
    rst = 1'b0;

    // single update
    ex_vld = 1'b1; ex_pc = 64'h1000; ex_target = 64'h2000; ex_type = 3'd3; ex_taken = 1'b1;
    #1;
    chk("s_req0", 64'(btb_wr_req), 64'd0);
    step(); ex_vld = 1'b0; #1;
    chk("s_req", 64'(btb_wr_req), 64'd1);
    chk("s_pc", btb_wr_pc, 64'h1000);
    chk("s_tgt", btb_wr_predict_pc, 64'h2000);
    chk("s_type", 64'(btb_wr_type), 64'd3);
    chk("s_taken", 64'(btb_wr_taken), 64'd1);
    chk("s_occ1", 64'(occ), 64'd1);
    step(); #1;
    chk("s_occ0", 64'(occ), 64'd0);
    chk("s_req_off", 64'(btb_wr_req), 64'd0);
    chk("s_gate_pc", btb_wr_pc, 64'd0);
    chk("s_gate_tgt", btb_wr_predict_pc, 64'd0);

    // contention under hold: cm, ex, cm, ex
    hold = 1'b1; ex_vld = 1'b1; cm_vld = 1'b1; ex_pc = 64'hE0; cm_pc = 64'hC0;
    ex_type = 3'd0; ex_taken = 1'b0;
    step(); cm_pc = 64'hC1; #1;
    chk("c_occ1", 64'(occ), 64'd1);
    chk("c_hold_req", 64'(btb_wr_req), 64'd0);
    step(); ex_pc = 64'hE1; #1;
    chk("c_occ2", 64'(occ), 64'd2);
    step(); cm_pc = 64'hC2; #1;
    chk("c_occ3", 64'(occ), 64'd3);
    step(); ex_pc = 64'hE2; #1;
    chk("c_occ4", 64'(occ), 64'd4);
    chk("c_full_exrdy", 64'(ex_rdy), 64'd0);
    chk("c_full_cmrdy", 64'(cm_rdy), 64'd0);
    hold = 1'b0; #1;
    chk("c_w0_req", 64'(btb_wr_req), 64'd1);
    chk("c_w0_pc", btb_wr_pc, 64'hC0);
    chk("c_w0_rdy", 64'(cm_rdy), 64'd0);
    step(); #1;
    chk("c_afterfull_occ", 64'(occ), 64'd3);
    chk("c_afterfull_rdy", 64'(cm_rdy), 64'd1);
    chk("c_w1_pc", btb_wr_pc, 64'hE0);
    step(); ex_vld = 1'b0; cm_vld = 1'b0; #1;
    chk("c_enqdeq_occ", 64'(occ), 64'd3);
    chk("c_w2_pc", btb_wr_pc, 64'hC1);
    step(); #1;
    chk("c_w3_pc", btb_wr_pc, 64'hE1);
    chk("c_occ_d2", 64'(occ), 64'd2);
    step(); #1;
    chk("c_w4_pc", btb_wr_pc, 64'hC2);
    step(); #1;
    chk("c_drain_occ", 64'(occ), 64'd0);
    chk("c_drain_req", 64'(btb_wr_req), 64'd0);

    // flush with occ=3 and a pending request
    hold = 1'b1; ex_vld = 1'b1; ex_pc = 64'h100;
    step(); ex_pc = 64'h104;
    step(); ex_pc = 64'h108;
    step();
    ex_vld = 1'b0; cm_vld = 1'b1; cm_pc = 64'h200; cm_target = 64'h208;
    hold = 1'b0; flush = 1'b1; #1;
    chk("f_occ3", 64'(occ), 64'd3);
    chk("f_req", 64'(btb_wr_req), 64'd0);
    chk("f_cmrdy", 64'(cm_rdy), 64'd0);
    step(); flush = 1'b0; #1;
    chk("f_occ0", 64'(occ), 64'd0);
    chk("f_req_empty", 64'(btb_wr_req), 64'd0);
    chk("f_rdy_back", 64'(cm_rdy), 64'd1);
    step(); cm_vld = 1'b0; #1;
    chk("f_post_req", 64'(btb_wr_req), 64'd1);
    chk("f_post_pc", btb_wr_pc, 64'h200);
    chk("f_post_occ", 64'(occ), 64'd1);
    step(); #1;
    chk("f_done_occ", 64'(occ), 64'd0);

    // same-PC updates queued back to back
    hold = 1'b1; ex_vld = 1'b1; ex_pc = 64'h40; ex_target = 64'h80; ex_type = 3'd1; ex_taken = 1'b0;
    step(); ex_target = 64'h88; ex_taken = 1'b1;
    step(); ex_vld = 1'b0; #1;
`ifdef BPU_UPD_COALESCE_EN
    chk("k_occ", 64'(occ), 64'd1);
`else
    chk("k_occ", 64'(occ), 64'd2);
`endif
    hold = 1'b0; #1;
    chk("k_req", 64'(btb_wr_req), 64'd1);
    chk("k_pc", btb_wr_pc, 64'h40);
`ifdef BPU_UPD_COALESCE_EN
    chk("k_taken", 64'(btb_wr_taken), 64'd1);
    chk("k_tgt", btb_wr_predict_pc, 64'h88);
    step(); #1;
    chk("k_end_occ", 64'(occ), 64'd0);
    chk("k_end_req", 64'(btb_wr_req), 64'd0);
`else
    chk("k_taken", 64'(btb_wr_taken), 64'd0);
    chk("k_tgt", btb_wr_predict_pc, 64'h80);
    step(); #1;
    chk("k_occ_mid", 64'(occ), 64'd1);
    chk("k_taken2", 64'(btb_wr_taken), 64'd1);
    chk("k_tgt2", btb_wr_predict_pc, 64'h88);
    step(); #1;
    chk("k_end_occ", 64'(occ), 64'd0);
`endif

    // asynchronous reset mid-operation
    hold = 1'b1; ex_vld = 1'b1; ex_pc = 64'h500;
    step(); ex_pc = 64'h504;
    step(); ex_vld = 1'b0; hold = 1'b0; #1;
    chk("r_pre_occ", 64'(occ), 64'd2);
    chk("r_pre_req", 64'(btb_wr_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("r_occ", 64'(occ), 64'd0);
    chk("r_req", 64'(btb_wr_req), 64'd0);
    chk("r_pc", btb_wr_pc, 64'd0);
    chk("r_exrdy", 64'(ex_rdy), 64'd1);
    rst = 1'b0;

    // after reset rr points at commit
    ex_vld = 1'b1; cm_vld = 1'b1; ex_pc = 64'h400; cm_pc = 64'h300;
    step(); cm_vld = 1'b0; #1;
    chk("a_first_pc", btb_wr_pc, 64'h300);
    step(); ex_vld = 1'b0; #1;
    chk("a_second_pc", btb_wr_pc, 64'h400);
    chk("a_occ", 64'(occ), 64'd1);
    step(); #1;
    chk("a_end_occ", 64'(occ), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bpu_upd_arb.md
# bpu_upd_arb

Update-side controller for the branch target buffer / branch history predictor. It arbitrates branch-resolution updates from the execute stage and the commit stage and buffers them in a small FIFO. It then sequences them onto the predictor's single write port, at most one write per cycle. It sits between the backend resolution logic and the predictor's `wr_req/wr_pc/wr_type/wr_predict_pc/wr_taken` inputs.

## Interface

Clocking: one clock `clk`. Reset `rst` is asynchronous and active-high.

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `PC_W`, 64: PC and target width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `ex_vld`  in  1  execute-stage update valid.
- `ex_rdy`  out  1  execute-stage update accepted when high together with `ex_vld`.
- `ex_pc`, `ex_target`  in  PC_W  branch PC and resolved target.
- `ex_type`  in  3  branch type code.
- `ex_taken`  in  1  resolved direction.
- `cm_vld`, `cm_rdy`, `cm_pc`, `cm_target`, `cm_type`, `cm_taken`: commit-stage requester, same widths and meaning as the `ex_*` ports.
- `hold`  in  1  frontend redirect in progress; suppresses writes.
- `flush`  in  1  discards all pending updates.
- `btb_wr_req`  out  1  write strobe to the predictor.
- `btb_wr_pc`, `btb_wr_predict_pc`  out  PC_W  head entry PC and target.
- `btb_wr_type`  out  3  head entry type.
- `btb_wr_taken`  out  1  head entry direction.
- `occ`  out  clog2(DEPTH)+1  entries held.

## Operation

- **Ready.** `ex_rdy` = `cm_rdy` = !full && !flush. Ready does not depend on a same-cycle dequeue.
- **Arbitration.** Round-robin, one grant per cycle.
  - If only one requester is valid and ready, that requester is granted.
  - If both are valid, the grant goes to the requester indicated by the 1-bit `rr` pointer. The other requester sees its `*_rdy` high but is not granted; that requester must hold its request.
  - `rr` points to the requester that was not granted, and updates only on a contended grant.
  - `rr` resets to commit.
- **Enqueue.** The granted request is written at `wptr`, `wptr` advances, and `occ` increments.
- **Dequeue.** While `occ`≠0 and !`hold` and !`flush`, `btb_wr_req`=1 and the `btb_wr_*` fields show the head entry. `rptr` advances and `occ` decrements that cycle.
- **Simultaneous enqueue and dequeue.** `occ` is unchanged.
- **Pointer wrap.** Pointers wrap modulo DEPTH. `occ` distinguishes the full and empty states.
- **Flush.** `flush` has the highest priority. In that cycle:
  - no grant is made;
  - `btb_wr_req`=0;
  - on the next edge, `wptr`, `rptr` and `occ` return to 0.
  - `rr` is unchanged.
- **Hold.** `hold` freezes dequeue only; enqueue continues until the FIFO is full.
- **Reset.** Takes effect immediately, even mid-operation:
  - `occ`=0, `btb_wr_req`=0, all `btb_wr_*`=0, `ex_rdy`=`cm_rdy`=1, `rr`=commit;
  - pending entries are lost.
- **Output gating.** When empty, the `btb_wr_*` data outputs are driven to 0, not left stale.

## Timing

- **Enqueue-to-write latency.** An update granted in cycle N produces `btb_wr_req` in cycle N+1 at the earliest (FIFO registered, no bypass).
- **Output timing.** `btb_wr_req` and the data outputs are combinational from registered FIFO state plus `hold`/`flush`. They carry no input-to-output path from the `ex_*`/`cm_*` ports.
- **Throughput.** One update per cycle sustained when `hold`=0.

## Configuration

- **`BPU_UPD_COALESCE_EN`**
  - **Defined:** a granted update whose PC equals the PC of the youngest queued entry overwrites that entry's type, target and taken fields instead of allocating a new entry. `occ` and `wptr` are unchanged.
  - **Eligibility:** the youngest entry must not be the one being dequeued in that cycle. It qualifies when `occ`≥2, or `occ`=1 with no dequeue that cycle.
  - **Ready:** still !full && !flush.
  - **Undefined:** every grant allocates a new entry; there is no PC compare logic.

## Test plan

- **Single update.** Reset, then `ex_vld`=1 for one cycle with pc=0x1000, target=0x2000, taken=1 → cycle+1: `btb_wr_req`=1, `btb_wr_pc`=0x1000, `btb_wr_predict_pc`=0x2000; `occ` goes 1→0.
- **Contention.** `ex` and `cm` valid every cycle with `hold`=1 → grants alternate cm, ex, cm, ex; `occ` reaches 4; both `rdy`=0 while full. Then release `hold` → 4 writes in grant order.
- **Full with simultaneous dequeue.** FIFO full, `hold`=0, both requesters valid → no grant that cycle (rdy=0), `occ`=3 next cycle; the grant happens the following cycle.
- **Flush.** `flush` with `occ`=3 and a request pending → `btb_wr_req`=0 that cycle, no grant, `occ`=0 next cycle; the next request is written one cycle after its grant.
- **Reset mid-operation.** Assert `rst` asynchronously with `occ`=2 → `btb_wr_req`=0 and `occ`=0 immediately; `rdy`=1.
- **Coalesce (BPU_UPD_COALESCE_EN).** With `hold`=1, enqueue pc=0x40 taken=0, then pc=0x40 taken=1 → `occ`=1; after release, a single write of pc=0x40 with taken=1. Without the macro: `occ`=2 and two writes.
